axi_rd_arbiter: RTL and testbench

//   Shares one AXI-lite-style memory read channel (AR + R) between two masters: m0 = IFU fetch, m1 = LSU load.

---
 rtl/axi_rd_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master read-channel arbiter: IFU (m0) and LSU (m1) share one AR/R slave port, one read in flight.
// Define ARB_RR_EN for round-robin arbitration; the default build gives the LSU fixed priority.
module axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_ARVALID,
    output logic              m0_ARREADY,
    input  logic [ADDR_W-1:0] m0_ARADDR,
    input  logic [2:0]        m0_ARPORT,
    output logic              m0_RVALID,
    input  logic              m0_RREADY,
    output logic [DATA_W-1:0] m0_RDATA,
    output logic [1:0]        m0_RRESP,
    input  logic              m1_ARVALID,
    output logic              m1_ARREADY,
    input  logic [ADDR_W-1:0] m1_ARADDR,
    input  logic [2:0]        m1_ARPORT,
    output logic              m1_RVALID,
    input  logic              m1_RREADY,
    output logic [DATA_W-1:0] m1_RDATA,
    output logic [1:0]        m1_RRESP,
    output logic              s_ARVALID,
    input  logic              s_ARREADY,
    output logic [ADDR_W-1:0] s_ARADDR,
    output logic [2:0]        s_ARPORT,
    input  logic              s_RVALID,
    output logic              s_RREADY,
    input  logic [DATA_W-1:0] s_RDATA,
    input  logic [1:0]        s_RRESP,
    output logic              busy
);

    // Handshakes are valid/ready: a transfer happens on a rising edge where both are high.
    typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

    state_t state;
    logic   gnt;
    logic   pick;
    logic   gnt_arvalid;
    logic   gnt_rready;

`ifdef ARB_RR_EN
    logic last;
    // A lone requester wins; a tie goes to whoever was not granted last time.
    assign pick = (m0_ARVALID && m1_ARVALID) ? ~last : m1_ARVALID;
`else
    assign pick = m1_ARVALID;
`endif

    assign gnt_arvalid = gnt ? m1_ARVALID : m0_ARVALID;
    assign gnt_rready  = gnt ? m1_RREADY  : m0_RREADY;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
`ifdef ARB_RR_EN
            last  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_ARVALID || m1_ARVALID) begin
                        gnt   <= pick;
                        state <= AR;
`ifdef ARB_RR_EN
                        last  <= pick;
`endif
                    end
                end
                AR: begin
                    // A withdrawn request ends the transaction without reaching the slave.
                    if (!gnt_arvalid) state <= IDLE;
                    else if (s_ARREADY) state <= R;
                end
                R: begin
                    if (s_RVALID && gnt_rready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m0_ARREADY = 1'b0;
        m1_ARREADY = 1'b0;
        m0_RVALID  = 1'b0;
        m1_RVALID  = 1'b0;
        m0_RDATA   = '0;
        m1_RDATA   = '0;
        m0_RRESP   = 2'b00;
        m1_RRESP   = 2'b00;
        s_ARVALID  = 1'b0;
        s_ARADDR   = '0;
        s_ARPORT   = 3'b000;
        s_RREADY   = 1'b0;
        case (state)
            AR: begin
                s_ARVALID = gnt_arvalid;
                s_ARADDR  = gnt ? m1_ARADDR : m0_ARADDR;
                s_ARPORT  = gnt ? m1_ARPORT : m0_ARPORT;
                if (gnt) m1_ARREADY = s_ARREADY;
                else     m0_ARREADY = s_ARREADY;
            end
            R: begin
                s_RREADY = gnt_rready;
                if (gnt) begin
                    m1_RVALID = s_RVALID;
                    m1_RDATA  = s_RDATA;
                    m1_RRESP  = s_RRESP;
                end else begin
                    m0_RVALID = s_RVALID;
                    m0_RDATA  = s_RDATA;
                    m0_RRESP  = s_RRESP;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed reads against a stalling slave model, AR and R scoreboards.
// Expected arbitration order follows ARB_RR_EN when it is defined.
module tb_axi_rd_arbiter;

    localparam int AW = 2 + 64 + 3;
    localparam int RW = 2 + 2 * (64 + 2);

    logic        clk;
    logic        rst;
    logic        m0_ARVALID, m0_ARREADY, m0_RVALID, m0_RREADY;
    logic [63:0] m0_ARADDR, m0_RDATA;
    logic [2:0]  m0_ARPORT;
    logic [1:0]  m0_RRESP;
    logic        m1_ARVALID, m1_ARREADY, m1_RVALID, m1_RREADY;
    logic [63:0] m1_ARADDR, m1_RDATA;
    logic [2:0]  m1_ARPORT;
    logic [1:0]  m1_RRESP;
    logic        s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
    logic [63:0] s_ARADDR, s_RDATA;
    logic [2:0]  s_ARPORT;
    logic [1:0]  s_RRESP;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ar_wait = 0;
    int r_wait = 0;

    logic [AW-1:0] exp_ar_q[$];
    logic [RW-1:0] exp_q[$];

    axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY), .m0_ARADDR(m0_ARADDR), .m0_ARPORT(m0_ARPORT),
        .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP),
        .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY), .m1_ARADDR(m1_ARADDR), .m1_ARPORT(m1_ARPORT),
        .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPORT(s_ARPORT),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .busy(busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        case (a)
            64'h8000_0000: mem_data = 64'h0000_0000_0010_0073;
            64'h8000_0004: mem_data = 64'h1111_2222_3333_4444;
            64'h8000_1000: mem_data = 64'hdead_beef_0000_1000;
            64'h8000_2000: mem_data = 64'hbad0_bad0_bad0_bad0;
            64'h8000_3000: mem_data = 64'h0123_4567_89ab_cdef;
            default:       mem_data = 64'h0;
        endcase
    endfunction

    // Slave model: ARREADY after ar_wait AR cycles, RVALID after r_wait R cycles; drives at posedge+2.
    initial begin : slave
        bit          ar_hs, r_hs;
        int          phase, cnt;
        logic [63:0] addr;
        phase = 0; cnt = 0; addr = '0;
        s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RDATA = '0; s_RRESP = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs = s_ARVALID && s_ARREADY;
            r_hs  = s_RVALID && s_RREADY;
            if (ar_hs) addr = s_ARADDR;
            @(posedge clk);
            #2;
            if (rst) begin
                phase = 0; cnt = 0;
                s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RDATA = '0; s_RRESP = 2'b00;
            end else begin
                if (phase == 0 && ar_hs) begin
                    phase = 1; cnt = 0;
                end else if (phase == 1 && r_hs) begin
                    phase = 0; cnt = 0;
                end
                if (phase == 0) begin
                    s_RVALID = 1'b0; s_RDATA = '0; s_RRESP = 2'b00;
                    if (s_ARVALID) begin
                        s_ARREADY = (cnt >= ar_wait);
                        if (cnt < ar_wait) cnt++;
                    end else begin
                        s_ARREADY = 1'b0;
                        cnt = 0;
                    end
                end else begin
                    s_ARREADY = 1'b0;
                    s_RVALID  = (cnt >= r_wait);
                    s_RDATA   = mem_data(addr);
                    s_RRESP   = (addr == 64'h8000_2000) ? 2'b10 : 2'b00;
                    if (cnt < r_wait) cnt++;
                end
            end
        end
    end

    function automatic logic [AW-1:0] ar_exp(input bit m, input logic [63:0] a, input logic [2:0] p);
        ar_exp = m ? {2'b10, a, p} : {2'b01, a, p};
    endfunction

    function automatic logic [RW-1:0] r_exp(input bit m, input logic [63:0] d, input logic [1:0] r);
        r_exp = m ? {2'b10, d, r, 64'h0, 2'b00} : {2'b01, 64'h0, 2'b00, d, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_ar(input bit m, input logic v, input logic [63:0] a, input logic [2:0] p);
        if (m) begin m1_ARVALID = v; m1_ARADDR = a; m1_ARPORT = p; end
        else   begin m0_ARVALID = v; m0_ARADDR = a; m0_ARPORT = p; end
    endtask

    // Driver: hold ARVALID until the handshake, then release it.
    task automatic master_read(input bit m, input logic [63:0] a, input logic [2:0] p);
        bit hs;
        int n;
        hs = 1'b0; n = 0;
        set_ar(m, 1'b1, a, p);
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = m ? (m1_ARVALID && m1_ARREADY) : (m0_ARVALID && m0_ARREADY);
            @(posedge clk);
            #1;
            n++;
        end
        set_ar(m, 1'b0, 64'h0, 3'b000);
        chk(m ? "m1_ar_timeout" : "m0_ar_timeout", {63'h0, hs}, 64'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("idle_timeout", {63'h0, busy}, 64'h0);
    endtask

    task automatic tie(input logic [63:0] a0, input logic [63:0] a1);
        fork
            master_read(1'b0, a0, 3'b100);
            master_read(1'b1, a1, 3'b001);
        join
        wait_idle();
    endtask

    initial begin : main
        rst = 1'b1;
        m0_ARVALID = 1'b0; m0_ARADDR = '0; m0_ARPORT = 3'b000; m0_RREADY = 1'b1;
        m1_ARVALID = 1'b0; m1_ARADDR = '0; m1_ARPORT = 3'b000; m1_RREADY = 1'b1;

        // Scoreboard monitor: compare each AR and R handshake against the queues.
        fork
            forever begin : monitor
                logic [AW-1:0] ea, aa;
                logic [RW-1:0] er, ar;
                @(negedge clk);
                if (!rst) begin
                    if (s_ARVALID && s_ARREADY) begin
                        checks++;
                        aa = {m1_ARREADY, m0_ARREADY, s_ARADDR, s_ARPORT};
                        if (exp_ar_q.size() == 0) begin
                            failures++;
                            $display("FAIL ar_unexpected actual=%h required=none", aa);
                        end else begin
                            ea = exp_ar_q.pop_front();
                            if (aa !== ea) begin
                                failures++;
                                $display("FAIL ar_handshake actual=%h required=%h", aa, ea);
                            end
                        end
                    end
                    if ((m0_RVALID && m0_RREADY) || (m1_RVALID && m1_RREADY)) begin
                        checks++;
                        ar = {m1_RVALID, m0_RVALID, m1_RDATA, m1_RRESP, m0_RDATA, m0_RRESP};
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL r_unexpected actual=%h required=none", ar);
                        end else begin
                            er = exp_q.pop_front();
                            if (ar !== er) begin
                                failures++;
                                $display("FAIL r_handshake actual=%h required=%h", ar, er);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_vr", {58'h0, m0_ARREADY, m1_ARREADY, m0_RVALID, m1_RVALID, s_ARVALID, s_RREADY}, 64'h0);
        chk("rst_s_araddr", s_ARADDR, 64'h0);
        chk("rst_m0_rdata", m0_RDATA, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single m0 read, cycle by cycle
        ar_wait = 0; r_wait = 0;
        @(posedge clk);
        #1;
        exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0000, 3'b100));
        exp_q.push_back(r_exp(1'b0, 64'h0000_0000_0010_0073, 2'b00));
        set_ar(1'b0, 1'b1, 64'h8000_0000, 3'b100);
        #2;
        chk("t1_idle_s_arvalid", {63'h0, s_ARVALID}, 64'h0);
        @(posedge clk);
        #3;
        chk("t1_s_arvalid", {63'h0, s_ARVALID}, 64'h1);
        chk("t1_s_araddr", s_ARADDR, 64'h8000_0000);
        chk("t1_s_arport", {61'h0, s_ARPORT}, 64'h4);
        chk("t1_m1_arready", {63'h0, m1_ARREADY}, 64'h0);
        @(posedge clk);
        #1;
        set_ar(1'b0, 1'b0, 64'h0, 3'b000);
        #2;
        chk("t1_m0_rdata", m0_RDATA, 64'h0000_0000_0010_0073);
        chk("t1_m1_rvalid", {63'h0, m1_RVALID}, 64'h0);
        @(posedge clk);
        #3;
        chk("t1_done_busy", {63'h0, busy}, 64'h0);

        // Simultaneous requests: m1 first in both modes, repeat tie after m0 again to m1
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_1000, 3'b001));
            exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0004, 3'b100));
            exp_q.push_back(r_exp(1'b1, 64'hdead_beef_0000_1000, 2'b00));
            exp_q.push_back(r_exp(1'b0, 64'h1111_2222_3333_4444, 2'b00));
            tie(64'h8000_0004, 64'h8000_1000);
            @(posedge clk);
            #1;
        end

        // Slave stalls: 4 AR cycles without ARREADY, 5 R cycles without RVALID
        ar_wait = 4; r_wait = 5;
        exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_3000, 3'b000));
        exp_q.push_back(r_exp(1'b1, 64'h0123_4567_89ab_cdef, 2'b00));
        fork
            master_read(1'b1, 64'h8000_3000, 3'b000);
            repeat (11) begin
                @(posedge clk);
                #3;
                chk("t3_busy", {63'h0, busy}, 64'h1);
            end
        join
        @(posedge clk);
        #3;
        chk("t3_done_busy", {63'h0, busy}, 64'h0);

        // Error response passes through
        ar_wait = 0; r_wait = 0;
        @(posedge clk);
        #1;
        exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_2000, 3'b000));
        exp_q.push_back(r_exp(1'b1, 64'hbad0_bad0_bad0_bad0, 2'b10));
        master_read(1'b1, 64'h8000_2000, 3'b000);
        wait_idle();

        // Reset during R abandons the read; then a normal read
        r_wait = 10;
        @(posedge clk);
        #1;
        exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0004, 3'b100));
        master_read(1'b0, 64'h8000_0004, 3'b100);
        rst = 1'b1;
        #2;
        chk("t5_in_r_busy", {63'h0, busy}, 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("t5_rst_busy", {63'h0, busy}, 64'h0);
        chk("t5_rst_vr", {58'h0, m0_ARREADY, m1_ARREADY, m0_RVALID, m1_RVALID, s_ARVALID, s_RREADY}, 64'h0);
        r_wait = 0;
        @(posedge clk);
        #1;
        exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0004, 3'b100));
        exp_q.push_back(r_exp(1'b0, 64'h1111_2222_3333_4444, 2'b00));
        master_read(1'b0, 64'h8000_0004, 3'b100);
        wait_idle();

        // m0 withdraws its request during AR
        ar_wait = 3;
        @(posedge clk);
        #1;
        set_ar(1'b0, 1'b1, 64'h8000_0000, 3'b100);
        @(posedge clk);
        #3;
        chk("t6_s_arvalid", {63'h0, s_ARVALID}, 64'h1);
        set_ar(1'b0, 1'b0, 64'h8000_0000, 3'b100);
        #1;
        chk("t6_drop_s_arvalid", {63'h0, s_ARVALID}, 64'h0);
        repeat (3) begin
            @(posedge clk);
            #3;
            chk("t6_idle", {62'h0, busy, m0_RVALID}, 64'h0);
        end

        // After a lone m1 grant, a tie separates fixed priority from round-robin
        ar_wait = 0;
        @(posedge clk);
        #1;
        exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_1000, 3'b001));
        exp_q.push_back(r_exp(1'b1, 64'hdead_beef_0000_1000, 2'b00));
        master_read(1'b1, 64'h8000_1000, 3'b001);
        wait_idle();
`ifdef ARB_RR_EN
        exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0000, 3'b100));
        exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_3000, 3'b001));
        exp_q.push_back(r_exp(1'b0, 64'h0000_0000_0010_0073, 2'b00));
        exp_q.push_back(r_exp(1'b1, 64'h0123_4567_89ab_cdef, 2'b00));
`else
        exp_ar_q.push_back(ar_exp(1'b1, 64'h8000_3000, 3'b001));
        exp_ar_q.push_back(ar_exp(1'b0, 64'h8000_0000, 3'b100));
        exp_q.push_back(r_exp(1'b1, 64'h0123_4567_89ab_cdef, 2'b00));
        exp_q.push_back(r_exp(1'b0, 64'h0000_0000_0010_0073, 2'b00));
`endif
        @(posedge clk);
        #1;
        tie(64'h8000_0000, 64'h8000_3000);

        repeat (3) @(posedge clk);
        #3;
        chk("ar_q_empty", 64'(exp_ar_q.size()), 64'h0);
        chk("r_q_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
